// File: rtl/dnn_pkg.sv
// Shared types and sizing for the 7-bit fixed-point inference engine and its
// downstream stages.
package dnn_pkg;

    localparam int unsigned ADDR_WIDTH  = 16;
    localparam int unsigned DATA_WIDTH  = 7;
    localparam int unsigned NUM_CLASSES = 10;
    localparam int unsigned IDX_WIDTH   = 4;

    typedef logic signed [DATA_WIDTH-1:0] score_t;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DONE
    } argmax_state_t;

endpackage

// File: rtl/argmax_cmp.sv
// Best/second-best score registers and compare-update logic for the argmax scan.
// Second-best tracking, margin and low_conf exist only when ARGMAX_CONF_EN is defined.
module argmax_cmp
    import dnn_pkg::*;
#(
    parameter int unsigned ScoreWidth = 7,
    parameter int unsigned ConfThresh = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         init_i,
    input  logic                         en_i,
    input  logic                         first_i,
    input  logic [IDX_WIDTH-1:0]         idx_i,
    input  logic signed [ScoreWidth-1:0] score_i,
    output logic signed [ScoreWidth-1:0] best_o,
`ifdef ARGMAX_CONF_EN
    input  logic                         latch_i,
    output logic [ScoreWidth-1:0]        margin_o,
    output logic                         low_conf_o,
`endif
    output logic [IDX_WIDTH-1:0]         digit_o
);

    localparam logic signed [ScoreWidth-1:0] MinScore = {1'b1, {(ScoreWidth-1){1'b0}}};

    logic signed [ScoreWidth-1:0] best_q, best_d;
    logic [IDX_WIDTH-1:0]         digit_q, digit_d;
    logic                         take;

    // Index 0 always loads so an all-minimum input still reports digit 0.
    assign take = en_i && (first_i || (score_i > best_q));

    always_comb begin
        best_d  = best_q;
        digit_d = digit_q;
        if (init_i) begin
            best_d  = MinScore;
            digit_d = '0;
        end else if (take) begin
            best_d  = score_i;
            digit_d = idx_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            best_q  <= '0;
            digit_q <= '0;
        end else begin
            best_q  <= best_d;
            digit_q <= digit_d;
        end
    end

    assign best_o  = best_q;
    assign digit_o = digit_q;

`ifdef ARGMAX_CONF_EN
    localparam logic [ScoreWidth:0] Thresh = (ScoreWidth+1)'(ConfThresh);

    logic signed [ScoreWidth-1:0] second_q, second_d;
    logic [ScoreWidth-1:0]        margin_q, margin_w;
    logic                         low_conf_q;

    always_comb begin
        second_d = second_q;
        if (init_i) begin
            second_d = MinScore;
        end else if (take) begin
            second_d = best_q;
        end else if (en_i && (score_i > second_q)) begin
            second_d = score_i;
        end
    end

    // best >= second always, so the wrapped difference is the exact 0..127 margin.
    assign margin_w = ScoreWidth'(best_q - second_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            second_q   <= '0;
            margin_q   <= '0;
            low_conf_q <= 1'b0;
        end else begin
            second_q <= second_d;
            if (latch_i) begin
                margin_q   <= margin_w;
                low_conf_q <= ({1'b0, margin_w} < Thresh);
            end
        end
    end

    assign margin_o   = margin_q;
    assign low_conf_o = low_conf_q;
`endif

endmodule

// File: rtl/dnn_argmax_fix7.sv
// Argmax over the engine's NUM_CLASSES output scores, one per cycle via out_idx.
// Optional confidence margin outputs enabled by defining ARGMAX_CONF_EN.
module dnn_argmax_fix7
    import dnn_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = 7,
    parameter int unsigned NUM_CLASSES = 10,
    parameter int unsigned CONF_THRESH = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start_i,
    output logic [IDX_WIDTH-1:0]         out_idx_o,
    input  logic signed [DATA_WIDTH-1:0] score_i,
    output logic                         busy_o,
    output logic                         valid_o,
    output logic [IDX_WIDTH-1:0]         digit_o,
`ifdef ARGMAX_CONF_EN
    output logic [DATA_WIDTH-1:0]        margin_o,
    output logic                         low_conf_o,
`endif
    output logic signed [DATA_WIDTH-1:0] max_score_o
);

    localparam logic [IDX_WIDTH-1:0] LastIdx = IDX_WIDTH'(NUM_CLASSES - 1);

    argmax_state_t        state_q, state_d;
    logic [IDX_WIDTH-1:0] idx_q, idx_d;
    logic                 valid_q, valid_d;
    logic                 init, scan_en, latch;

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        valid_d   = valid_q;
        init      = 1'b0;
        scan_en   = 1'b0;
        latch     = 1'b0;
        out_idx_o = '0;
        busy_o    = 1'b0;
        unique case (state_q)
            IDLE, DONE: begin
                if (start_i) begin
                    valid_d = 1'b0;
                    init    = 1'b1;
                    idx_d   = '0;
                    state_d = SCAN;
                end else if (state_q == DONE && !valid_q) begin
                    // One settle cycle in DONE before the result is flagged.
                    valid_d = 1'b1;
                    latch   = 1'b1;
                end
            end
            SCAN: begin
                busy_o    = 1'b1;
                out_idx_o = idx_q;
                scan_en   = 1'b1;
                if (idx_q == LastIdx) begin
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
        end
    end

    assign valid_o = valid_q;

    argmax_cmp #(
        .ScoreWidth (DATA_WIDTH),
        .ConfThresh (CONF_THRESH)
    ) u_cmp (
        .clk        (clk),
        .rst_n      (rst_n),
        .init_i     (init),
        .en_i       (scan_en),
        .first_i    (idx_q == '0),
        .idx_i      (idx_q),
        .score_i    (score_i),
        .best_o     (max_score_o),
`ifdef ARGMAX_CONF_EN
        .latch_i    (latch),
        .margin_o   (margin_o),
        .low_conf_o (low_conf_o),
`endif
        .digit_o    (digit_o)
    );

endmodule
